// File: rtl/uart_tx_en.sv
// ---------------------------------------------------------------------------
// uart_tx_en
//   8N1 UART transmitter paced by an external baud/oversample tick. Each bit
//   (start, eight data bits LSB first, stop) lasts Oversample ticks of 'en',
//   so the transmitter can share the tick generator of the oversampling
//   receiver. A one-entry holding register accepts the next byte through a
//   valid/ready handshake while the current frame is still shifting out, which
//   lets frames follow each other with no idle gap on the line.
//
// Parameters
//   Oversample  en ticks per bit (>= 2)
//
// Ports
//   clk     in   system clock, all state changes on the rising edge
//   nReset  in   asynchronous, active-low reset
//   en      in   baud/oversample tick; the line state only advances when high
//   valid   in   byte on 'data' is valid; taken when valid && ready
//   data    in   byte to transmit (8 bits, LSB first on the line)
//   ready   out  holding register empty, a byte can be accepted
//   out     out  registered serial line, idles high
//   busy    out  a frame is in progress (state is not IDLE)
//   done    out  single clk pulse when a stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_en #(
    parameter int Oversample = 16
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       en,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);

    localparam int CntW = (Oversample > 1) ? $clog2(Oversample) : 1;
    localparam logic [CntW-1:0] TickReload = CntW'(Oversample - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState;

    txState          state;
    txState          stateNext;
    logic [CntW-1:0] tickCnt;
    logic [CntW-1:0] tickNext;
    logic [2:0]      bitCnt;
    logic [2:0]      bitNext;
    logic [7:0]      shiftReg;
    logic [7:0]      shiftNext;
    logic            outNext;
    logic            doneNext;
    logic [7:0]      holdReg;
    logic            holdFull;
    logic            loadHold;
    logic            periodEnd;

    // A bit period finishes on the tick where the down-counter has reached
    // zero; the counter is then reloaded for the next period.
    assign periodEnd = (tickCnt == '0);

    // The holding register is the only thing the handshake looks at, so ready
    // simply mirrors its empty flag; busy is any non-idle state.
    assign ready = ~holdFull;
    assign busy  = (state != IDLE);

    // Next-state and datapath logic. Nothing on the line side moves unless
    // en is high. Starting a frame (from IDLE or straight out of STOP) copies
    // the holding register into the shift register, frees the holding
    // register and drives the start bit on the same edge. The shift register
    // is shifted right so that bit 0 always holds the next bit to send.
    always_comb begin
        stateNext = state;
        tickNext  = tickCnt;
        bitNext   = bitCnt;
        shiftNext = shiftReg;
        outNext   = out;
        doneNext  = 1'b0;
        loadHold  = 1'b0;

        case (state)
            IDLE: begin
                outNext = 1'b1;
                if (en && holdFull) begin
                    stateNext = START;
                    loadHold  = 1'b1;
                    shiftNext = holdReg;
                    tickNext  = TickReload;
                    bitNext   = 3'd0;
                    outNext   = 1'b0;
                end
            end

            START: begin
                if (en) begin
                    if (periodEnd) begin
                        stateNext = DATA;
                        tickNext  = TickReload;
                        bitNext   = 3'd0;
                        outNext   = shiftReg[0];
                        shiftNext = {1'b0, shiftReg[7:1]};
                    end else begin
                        tickNext = tickCnt - CntW'(1);
                    end
                end
            end

            DATA: begin
                if (en) begin
                    if (periodEnd) begin
                        tickNext = TickReload;
                        if (bitCnt == 3'd7) begin
                            stateNext = STOP;
                            outNext   = 1'b1;
                        end else begin
                            bitNext   = bitCnt + 3'd1;
                            outNext   = shiftReg[0];
                            shiftNext = {1'b0, shiftReg[7:1]};
                        end
                    end else begin
                        tickNext = tickCnt - CntW'(1);
                    end
                end
            end

            STOP: begin
                if (en) begin
                    if (periodEnd) begin
                        doneNext = 1'b1;
                        tickNext = TickReload;
                        bitNext  = 3'd0;
                        if (holdFull) begin
                            stateNext = START;
                            loadHold  = 1'b1;
                            shiftNext = holdReg;
                            outNext   = 1'b0;
                        end else begin
                            stateNext = IDLE;
                            outNext   = 1'b1;
                        end
                    end else begin
                        tickNext = tickCnt - CntW'(1);
                    end
                end
            end

            default: begin
                stateNext = IDLE;
                tickNext  = TickReload;
                bitNext   = 3'd0;
                outNext   = 1'b1;
            end
        endcase
    end

    // State register for the transmit side. Reset forces the line high at
    // once, so a frame in progress is cut off immediately.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            tickCnt  <= TickReload;
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
            out      <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= stateNext;
            tickCnt  <= tickNext;
            bitCnt   <= bitNext;
            shiftReg <= shiftNext;
            out      <= outNext;
            done     <= doneNext;
        end
    end

    // Holding register and handshake, independent of en. A load into the
    // shift register can only happen while the register is full, and a new
    // byte is only taken while it is empty, so the two never coincide. A byte
    // taken on the same edge that STOP ends is only seen by the FSM on the
    // following tick. Reset discards whatever was waiting here.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            holdReg  <= 8'h00;
            holdFull <= 1'b0;
        end else if (loadHold) begin
            holdFull <= 1'b0;
        end else if (valid && !holdFull) begin
            holdReg  <= data;
            holdFull <= 1'b1;
        end
    end

endmodule
